// File: rtl/pseudo_dual_port_ram_pkg.sv
// Shared constants for the pseudo dual-port RAM: default widths and the depth helper.
// Port widths always come from module parameters; these values only seed the defaults.
package pseudo_dual_port_ram_pkg;

  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH    = 8;

  function automatic int unsigned depth(input int unsigned address_width);
    return 32'd1 << address_width;
  endfunction

endpackage

// File: rtl/pseudo_dual_port_ram_array.sv
// Storage array for the pseudo dual-port RAM: synchronous write, combinational indexed read.
// Written as a plain unreset array so synthesis maps it onto block RAM.
module pseudo_dual_port_ram_array
  import pseudo_dual_port_ram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     write_enable,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0]    read_data
);

  logic [DATA_WIDTH-1:0] mem [depth(ADDRESS_WIDTH)];

  // NOTE: the storage has no reset; adding one would block RAM inference and
  // turn the array into flip-flops. Contents are undefined until written.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  assign read_data = mem[read_address];

endmodule

// File: rtl/pseudo_dual_port_ram.sv
// Pseudo dual-port RAM top: one write port, one registered read port, one clock.
// Define PDP_RAM_WRITE_FORWARD_EN for write-first collisions; default is read-first.
module pseudo_dual_port_ram
  import pseudo_dual_port_ram_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     ReadEnable_i,
  input  logic                     WriteEnable_i,
  input  logic [ADDRESS_WIDTH-1:0] ReadAddress_i,
  input  logic [ADDRESS_WIDTH-1:0] WriteAddress_i,
  input  logic [DATA_WIDTH-1:0]    Data_i,
  output logic [DATA_WIDTH-1:0]    Data_o
);

  logic                  write_enable;
  logic [DATA_WIDTH-1:0] array_data;
  logic [DATA_WIDTH-1:0] read_word;

  // Memory itself is never cleared, so writes must be blocked while reset is held.
  assign write_enable = WriteEnable_i & Reset;

  pseudo_dual_port_ram_array #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_array (
    .clk          (Clock),
    .write_enable (write_enable),
    .write_address(WriteAddress_i),
    .write_data   (Data_i),
    .read_address (ReadAddress_i),
    .read_data    (array_data)
  );

  // NOTE: read_word gets its default first so no path through the block can
  // leave it unassigned and infer a latch.
  always_comb begin
    read_word = array_data;
`ifdef PDP_RAM_WRITE_FORWARD_EN
    if (WriteEnable_i && (ReadAddress_i == WriteAddress_i)) begin
      read_word = Data_i;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Data_o <= '0;
    end else if (ReadEnable_i) begin
      Data_o <= read_word;
    end
  end

endmodule

// File: tb/tb_pseudo_dual_port_ram.sv
// Self-checking bench for pseudo_dual_port_ram (ADDRESS_WIDTH=4, DATA_WIDTH=8).
// Stimulus pushes the hand-computed Data_o for each cycle; a negedge monitor pops and compares.
module tb_pseudo_dual_port_ram;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          ReadEnable_i;
  logic          WriteEnable_i;
  logic [AW-1:0] ReadAddress_i;
  logic [AW-1:0] WriteAddress_i;
  logic [DW-1:0] Data_i;
  logic [DW-1:0] Data_o;

  logic [DW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;

  pseudo_dual_port_ram #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .ReadEnable_i  (ReadEnable_i),
    .WriteEnable_i (WriteEnable_i),
    .ReadAddress_i (ReadAddress_i),
    .WriteAddress_i(WriteAddress_i),
    .Data_i        (Data_i),
    .Data_o        (Data_o)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: Data_o is sampled on the falling edge, away from the active edge.
  always @(negedge Clock) begin
    if (exp_q.size() != 0) begin
      check("data_o", Data_o, exp_q.pop_front());
    end
  end

  // One clock of stimulus; exp is the Data_o value expected after this edge.
  task automatic cycle(input logic re, input logic [AW-1:0] ra,
                       input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp);
    ReadEnable_i   = re;
    ReadAddress_i  = ra;
    WriteEnable_i  = we;
    WriteAddress_i = wa;
    Data_i         = d;
    exp_q.push_back(exp);
    @(posedge Clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge Clock);
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  logic [DW-1:0] collide_exp;

  initial begin
    Reset          = 1'b0;
    ReadEnable_i   = 1'b0;
    WriteEnable_i  = 1'b0;
    ReadAddress_i  = '0;
    WriteAddress_i = '0;
    Data_i         = '0;
    #1;
    check("reset_value", Data_o, 8'h00);

    // Enables toggle under reset: output stays 0 and requests are ignored.
    cycle(1'b1, 4'd0, 1'b1, 4'd0, 8'hFF, 8'h00);
    cycle(1'b0, 4'd1, 1'b0, 4'd1, 8'hEE, 8'h00);
    Reset = 1'b1;
    cycle(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 8'h00);
    cycle(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 8'h00);

    // Fill, then back-to-back read of the whole array.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'd0, 1'b1, 4'(i), 8'hA0 + 8'(i), 8'h00);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(i), 1'b0, 4'd0, 8'h00, 8'hA0 + 8'(i));
    end

    // Hold with read disabled while the read address is rewritten.
    cycle(1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 8'hA3);
    cycle(1'b0, 4'd3, 1'b1, 4'd3, 8'h55, 8'hA3);
    cycle(1'b0, 4'd3, 1'b0, 4'd0, 8'h00, 8'hA3);
    cycle(1'b1, 4'd3, 1'b0, 4'd0, 8'h00, 8'h55);

    // Same-address collision.
`ifdef PDP_RAM_WRITE_FORWARD_EN
    collide_exp = 8'h3C;
`else
    collide_exp = 8'hA7;
`endif
    cycle(1'b1, 4'd7, 1'b1, 4'd7, 8'h3C, collide_exp);
    cycle(1'b1, 4'd7, 1'b0, 4'd0, 8'h00, 8'h3C);

    // Independent read and write at different addresses.
    cycle(1'b1, 4'd9, 1'b1, 4'd2, 8'h11, 8'hA9);
    cycle(1'b1, 4'd2, 1'b0, 4'd0, 8'h00, 8'h11);

    // Mid-burst asynchronous reset; memory survives it.
    cycle(1'b0, 4'd0, 1'b1, 4'd5, 8'h99, 8'h11);
    cycle(1'b1, 4'd4, 1'b0, 4'd0, 8'h00, 8'hA4);
    cycle(1'b1, 4'd5, 1'b0, 4'd0, 8'h00, 8'h99);
    cycle(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 8'h99);
    drain();
    check("pre_reset_hold", Data_o, 8'h99);
    ReadEnable_i   = 1'b1;
    ReadAddress_i  = 4'd6;
    WriteEnable_i  = 1'b1;
    WriteAddress_i = 4'd5;
    Data_i         = 8'h00;
    Reset          = 1'b0;
    #1;
    check("async_reset_drop", Data_o, 8'h00);
    cycle(1'b1, 4'd6, 1'b1, 4'd5, 8'h00, 8'h00);
    cycle(1'b0, 4'd5, 1'b1, 4'd5, 8'h77, 8'h00);
    Reset = 1'b1;
    cycle(1'b0, 4'd5, 1'b0, 4'd0, 8'h00, 8'h00);
    cycle(1'b1, 4'd5, 1'b0, 4'd0, 8'h00, 8'h99);
    cycle(1'b1, 4'd6, 1'b0, 4'd0, 8'h00, 8'hA6);
    cycle(1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 8'hA6);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pseudo_dual_port_ram.md
PSEUDO_DUAL_PORT_RAM -- requirements
Module: pseudo_dual_port_ram

Interface
REQ-001 Parameters SHALL be exactly the following.
- ADDRESS_WIDTH, default 8: address bits per port; depth = 2**ADDRESS_WIDTH words.
- DATA_WIDTH, default 8: bits per word.

REQ-002 Ports SHALL be exactly the following.
- Clock  input  1  single clock for both ports; all sampling on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ReadEnable_i  input  1  read request.
- WriteEnable_i  input  1  write request.
- ReadAddress_i  input  ADDRESS_WIDTH  read word address.
- WriteAddress_i  input  ADDRESS_WIDTH  write word address.
- Data_i  input  DATA_WIDTH  write data.
- Data_o  output  DATA_WIDTH  registered read data.

REQ-003 The block SHALL have one clock, with asynchronous active-low reset (Reset=0 resets).

Function
REQ-004 Write: on a rising Clock edge with Reset=1 and WriteEnable_i=1, Memory[WriteAddress_i] SHALL take Data_i. With WriteEnable_i=0, memory SHALL be unchanged.
REQ-005 Read: on a rising Clock edge with Reset=1 and ReadEnable_i=1, Data_o SHALL take Memory[ReadAddress_i].
- Latency is exactly 1 cycle.
- One read per cycle, back-to-back reads allowed.
REQ-006 With ReadEnable_i=0, Data_o SHALL hold its last value indefinitely.
REQ-007 Read and write ports SHALL operate independently in the same cycle, at any address combination. There is no handshake, no stall and no busy output.
REQ-008 Same-address collision (both enables=1, ReadAddress_i==WriteAddress_i): Data_o SHALL return the pre-write (old) contents, unless REQ-013 applies. The write still completes.
REQ-009 Addresses SHALL cover the full range 0..2**ADDRESS_WIDTH-1, with no wrap logic, no out-of-range case and no error output.
REQ-010 Memory contents after power-up SHALL be undefined. The block SHALL contain no initialisation logic.

Reset
REQ-011 While Reset=0, Data_o SHALL be 0, forced asynchronously, and all read and write requests SHALL be ignored.
REQ-012 Reset SHALL NOT clear memory contents. Data written before a mid-operation reset SHALL remain readable after Reset returns to 1. The first read result SHALL appear on the edge after the read is requested.

Configuration
REQ-013 Macro PDP_RAM_WRITE_FORWARD_EN SHALL control same-address collisions.
- Defined: on a collision as in REQ-008, Data_o SHALL take Data_i (write-first forwarding).
- Undefined: read-first behaviour per REQ-008, and no forwarding logic SHALL be present.
- All other behaviour SHALL be identical in both builds.

Structure
REQ-014 A shared package SHALL hold default width constants (ADDRESS_WIDTH=8, DATA_WIDTH=8) and a derived depth helper. Port widths SHALL come from module parameters, not the package.
REQ-015 The storage array SHALL be a sub-module, pseudo_dual_port_ram_array, providing the synchronous write and the combinational indexed read.
- The top level SHALL own the Data_o register, reset and forwarding mux.
- The array SHALL infer block RAM, with no reset on the storage.

Verification
All scenarios use ADDRESS_WIDTH=4, DATA_WIDTH=8.
REQ-016 Hold Reset=0 for 2 cycles with enables toggling -> Data_o=0x00 and memory untouched; release Reset -> Data_o stays 0x00 until a read.
REQ-017 Write addresses 0..15 with values 0xA0..0xAF on consecutive cycles, then read 0..15 back-to-back -> Data_o equals 0xA0..0xAF, each one cycle after its address.
REQ-018 ReadEnable_i=0 after reading address 3 (0xA3) while writing address 3=0x55 -> Data_o stays 0xA3; a later read of 3 -> 0x55.
REQ-019 Same-cycle write addr 7=0x3C and read addr 7 (old 0xA7) -> Data_o=0xA7 without the macro and 0x3C with PDP_RAM_WRITE_FORWARD_EN; the next read of 7 -> 0x3C in both builds.
REQ-020 Assert Reset=0 mid-read-burst after address 5 was written with 0x99 -> Data_o drops to 0x00 immediately, without waiting for a clock edge; after release, read 5 -> 0x99.
REQ-021 Simultaneous write addr 2=0x11 and read addr 9 -> Data_o=0xA9 next cycle; then read 2 -> 0x11.
